// File: rtl/shift_add_mult_if.sv
// shift_add_mult_if: start/busy/done handshake and operand/product bus for shift_add_mult
interface shift_add_mult_if #(parameter int WIDTH = 4);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2*WIDTH-1:0] product;
  logic busy;
  logic done;
  modport master (output start, a, b, input product, busy, done);
  modport slave (input start, a, b, output product, busy, done);
endinterface

// File: rtl/shift_add_mult.sv
// shift_add_mult: sequential shift-and-add unsigned multiplier, one partial product per cycle
// Optional SHIFT_ADD_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module shift_add_mult #(
  parameter int WIDTH = 4
) (
  input logic clk,
  input logic rst_n,
  shift_add_mult_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] m_reg, q_reg;
  logic [2*WIDTH-1:0] acc, acc_n, prod_reg;
  logic [CW-1:0] count;
  logic last;
  assign acc_n = acc + ({{WIDTH{1'b0}}, m_reg & {WIDTH{q_reg[0]}}} << count);
`ifdef SHIFT_ADD_EARLY_EXIT_EN
  assign last = (q_reg >> 1) == '0;
`else
  assign last = count == CW'(WIDTH - 1);
`endif
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (bus.start ? RUN : IDLE) :
              (state == RUN) ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reg <= '0;
      q_reg <= '0;
      acc <= '0;
      count <= '0;
      prod_reg <= '0;
    end else if (state == IDLE && bus.start) begin
      m_reg <= bus.a;
      q_reg <= bus.b;
      acc <= '0;
      count <= '0;
    end else if (state == RUN) begin
      acc <= acc_n;
      q_reg <= q_reg >> 1;
      count <= count + 1'b1;
      if (last) prod_reg <= acc_n;
    end
  end
  assign bus.product = prod_reg;
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
endmodule
